// File: rtl/rv32i_types.sv
// Shared RV32 pipeline types: reservation-station entry, CDB broadcast, M-extension
// opcodes, and the dispatch-time source-readiness rule used by the mul/div station.
package rv32i_types;

   localparam int MULDIV_RS_DEPTH = 4;
   localparam int PR_IDX_W        = 6;
   localparam int ROB_IDX_W       = 4;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } m_funct3_e;

   typedef struct packed {
      logic [2:0]           funct3;
      logic [ROB_IDX_W-1:0] rob_id;
      logic [4:0]           rd_addr;
      logic [PR_IDX_W-1:0]  pd_addr;
      logic [PR_IDX_W-1:0]  ps1_addr;
      logic [PR_IDX_W-1:0]  ps2_addr;
      logic                 ps1_ready;
      logic                 ps2_ready;
   } rs_entry_t;

   typedef struct packed {
      logic                 ready;
      logic [PR_IDX_W-1:0]  pr_dest;
      logic [ROB_IDX_W-1:0] rob_id;
      logic [31:0]          rd_data;
   } cdb_t;

   // x0 is always ready; a same-cycle broadcast of the source must not be lost.
   function automatic logic src_ready_at_dispatch(input logic                rdy,
                                                  input logic [PR_IDX_W-1:0] addr,
                                                  input cdb_t                bc);
      return rdy | (addr == '0) | (bc.ready & (bc.pr_dest == addr) & (addr != '0));
   endfunction

endpackage

// File: rtl/muldiv_rs_select.sv
// Issue arbiter for muldiv_rs: issuable vector to one-hot grant. With
// MULDIV_RS_OLDEST_FIRST_EN the smallest age stamp wins, otherwise the lowest index.
module muldiv_rs_select
   import rv32i_types::*;
#(
   parameter int DEPTH = MULDIV_RS_DEPTH
) (
   input  logic [DEPTH-1:0]                      issuable_i,
`ifdef MULDIV_RS_OLDEST_FIRST_EN
   input  logic [DEPTH-1:0][$clog2(DEPTH)-1:0]   age_i,
`endif
   output logic [DEPTH-1:0]                      grant_o,
   output logic                                  grant_valid_o
);

   assign grant_valid_o = |issuable_i;

`ifdef MULDIV_RS_OLDEST_FIRST_EN
   // Ages of valid slots are unique, so at most one issuable slot survives.
   always_comb begin
      // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
      grant_o = issuable_i;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if ((j != i) && issuable_i[j] && (age_i[j] < age_i[i])) grant_o[i] = 1'b0;
         end
      end
   end
`else
   always_comb begin
      grant_o = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (issuable_i[i]) begin
            grant_o    = '0;
            grant_o[i] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/muldiv_rs.sv
// Reservation station for the sequential mul/div unit: dispatch, CDB wakeup, single issue.
// MULDIV_RS_OLDEST_FIRST_EN selects oldest-first issue (compacted age stamps).
module muldiv_rs
   import rv32i_types::*;
#(
   parameter  int DEPTH = MULDIV_RS_DEPTH,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                dispatch_valid,
   input  rs_entry_t           dispatch_entry,
   output logic                dispatch_ready,
   input  cdb_t                cdb,
   input  logic                fu_ready,
   output logic                rs_entry_valid,
   output rs_entry_t           rs_entry_dout,
   output logic [PR_IDX_W-1:0] ps1_addr,
   output logic [PR_IDX_W-1:0] ps2_addr,
   output logic [IDX_W:0]      occupancy
);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] src1_rdy_q, src1_rdy_d;
   logic [DEPTH-1:0] src2_rdy_q, src2_rdy_d;
   logic [IDX_W:0]   occ_q, occ_d;
   rs_entry_t        entry_q [DEPTH];

   logic [DEPTH-1:0] issuable, grant;
   logic             grant_valid, disp_fire, issue_fire, wake;
   logic [IDX_W-1:0] alloc_idx, sel_idx;

   // Only ready/pr_dest matter for wakeup; the rest of the broadcast is for other consumers.
   logic cdb_unused;
   assign cdb_unused = ^{cdb.rob_id, cdb.rd_data};

   assign dispatch_ready = ~&valid_q;
   assign disp_fire      = dispatch_valid & dispatch_ready & ~flush;
   assign issuable       = valid_q & src1_rdy_q & src2_rdy_q;
   assign wake           = cdb.ready & (cdb.pr_dest != '0);

   // Lowest free slot as seen at the start of the cycle.
   always_comb begin
      alloc_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_idx = IDX_W'(i);
      end
   end

`ifdef MULDIV_RS_OLDEST_FIRST_EN
   logic [DEPTH-1:0][IDX_W-1:0] age_q, age_d;
   logic [IDX_W-1:0]            sel_age, new_age;

   muldiv_rs_select #(.DEPTH(DEPTH)) u_select (
      .issuable_i    (issuable),
      .age_i         (age_q),
      .grant_o       (grant),
      .grant_valid_o (grant_valid)
   );
`else
   muldiv_rs_select #(.DEPTH(DEPTH)) u_select (
      .issuable_i    (issuable),
      .grant_o       (grant),
      .grant_valid_o (grant_valid)
   );
`endif

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) sel_idx = IDX_W'(i);
      end
   end

   assign rs_entry_valid = grant_valid & fu_ready & ~flush;
   assign issue_fire     = rs_entry_valid;
   assign rs_entry_dout  = entry_q[sel_idx];
   assign ps1_addr       = rs_entry_dout.ps1_addr;
   assign ps2_addr       = rs_entry_dout.ps2_addr;
   assign occupancy      = occ_q;

   always_comb begin
      valid_d    = valid_q;
      src1_rdy_d = src1_rdy_q;
      src2_rdy_d = src2_rdy_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (wake && valid_q[i] && (entry_q[i].ps1_addr == cdb.pr_dest)) src1_rdy_d[i] = 1'b1;
         if (wake && valid_q[i] && (entry_q[i].ps2_addr == cdb.pr_dest)) src2_rdy_d[i] = 1'b1;
         if (issue_fire && grant[i]) valid_d[i] = 1'b0;
         if (disp_fire && (alloc_idx == IDX_W'(i))) begin
            valid_d[i]    = 1'b1;
            src1_rdy_d[i] = src_ready_at_dispatch(dispatch_entry.ps1_ready, dispatch_entry.ps1_addr, cdb);
            src2_rdy_d[i] = src_ready_at_dispatch(dispatch_entry.ps2_ready, dispatch_entry.ps2_addr, cdb);
         end
      end
      if (flush) valid_d = '0;
      occ_d = flush ? '0 : occ_q + (IDX_W+1)'(disp_fire) - (IDX_W+1)'(issue_fire);
   end

`ifdef MULDIV_RS_OLDEST_FIRST_EN
   // Age = number of older entries still resident; issue closes the gap above it.
   always_comb begin
      sel_age = age_q[sel_idx];
      new_age = IDX_W'(occ_q - (IDX_W+1)'(issue_fire));
      age_d   = age_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_fire && valid_q[i] && (age_q[i] > sel_age)) age_d[i] = age_q[i] - IDX_W'(1);
         if (disp_fire && (alloc_idx == IDX_W'(i))) age_d[i] = new_age;
      end
   end

   always_ff @(posedge clk) begin
      age_q <= age_d;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         src1_rdy_q <= '0;
         src2_rdy_q <= '0;
         occ_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         src1_rdy_q <= src1_rdy_d;
         src2_rdy_q <= src2_rdy_d;
         occ_q      <= occ_d;
      end
   end

   // NOTE: the payload array is not reset; valid_q alone decides whether a slot's contents matter.
   always_ff @(posedge clk) begin
      if (disp_fire) entry_q[alloc_idx] <= dispatch_entry;
   end

endmodule

// File: tb/tb_muldiv_rs.sv
// Self-checking bench for muldiv_rs: directed scenarios plus randomized traffic against
// a dispatch-ordered queue model of the station.
module tb_muldiv_rs;
   import rv32i_types::*;

   localparam int DEPTH = MULDIV_RS_DEPTH;
   localparam int IDX_W = $clog2(DEPTH);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                flush = 1'b0;
   logic                dispatch_valid = 1'b0;
   rs_entry_t           dispatch_entry = '0;
   logic                dispatch_ready;
   cdb_t                cdb = '0;
   logic                fu_ready = 1'b0;
   logic                rs_entry_valid;
   rs_entry_t           rs_entry_dout;
   logic [PR_IDX_W-1:0] ps1_addr, ps2_addr;
   logic [IDX_W:0]      occupancy;

   int vectors     = 0;
   int miscompares = 0;
   bit mon_en      = 1'b0;

   always #5 clk = ~clk;

   muldiv_rs #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .dispatch_valid (dispatch_valid),
      .dispatch_entry (dispatch_entry),
      .dispatch_ready (dispatch_ready),
      .cdb            (cdb),
      .fu_ready       (fu_ready),
      .rs_entry_valid (rs_entry_valid),
      .rs_entry_dout  (rs_entry_dout),
      .ps1_addr       (ps1_addr),
      .ps2_addr       (ps2_addr),
      .occupancy      (occupancy)
   );

   // Reference model: resident entries in dispatch order, each with its slot and readiness.
   typedef struct {
      int        slot;
      rs_entry_t e;
      bit        r1;
      bit        r2;
   } m_t;
   m_t mq[$];

   always @(negedge clk) begin : monitor
      int  cand;
      int  fs;
      bit  used;
      bit  exp_valid;
      m_t  n;
      cand = -1;
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].r1 && mq[i].r2) begin
`ifdef MULDIV_RS_OLDEST_FIRST_EN
            if (cand < 0) cand = i;
`else
            if (cand < 0 || mq[i].slot < mq[cand].slot) cand = i;
`endif
         end
      end
      exp_valid = (cand >= 0) && fu_ready && !flush;
      if (mon_en && !rst) begin
         vectors++;
         if (rs_entry_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL model_valid @%0t: got %0b expected %0b", $time, rs_entry_valid, exp_valid);
         end
         if (exp_valid && (rs_entry_dout !== mq[cand].e || ps1_addr !== mq[cand].e.ps1_addr ||
                           ps2_addr !== mq[cand].e.ps2_addr)) begin
            miscompares++;
            $display("FAIL model_dout @%0t: got %h (ps1 %0d ps2 %0d) expected %h", $time,
                     rs_entry_dout, ps1_addr, ps2_addr, mq[cand].e);
         end
         if (dispatch_ready !== (mq.size() < DEPTH) || occupancy !== (IDX_W+1)'(mq.size())) begin
            miscompares++;
            $display("FAIL model_occ @%0t: got ready %0b occ %0d expected ready %0b occ %0d", $time,
                     dispatch_ready, occupancy, mq.size() < DEPTH, mq.size());
         end
      end
      if (rst || flush) begin
         mq.delete();
      end else begin
         fs = -1;
         for (int s = DEPTH - 1; s >= 0; s--) begin
            used = 1'b0;
            foreach (mq[k]) if (mq[k].slot == s) used = 1'b1;
            if (!used) fs = s;
         end
         if (exp_valid) mq.delete(cand);
         if (cdb.ready && cdb.pr_dest != 0) begin
            foreach (mq[k]) begin
               if (mq[k].e.ps1_addr == cdb.pr_dest) mq[k].r1 = 1'b1;
               if (mq[k].e.ps2_addr == cdb.pr_dest) mq[k].r2 = 1'b1;
            end
         end
         if (dispatch_valid && fs >= 0) begin
            n.slot = fs;
            n.e    = dispatch_entry;
            n.r1   = dispatch_entry.ps1_ready || dispatch_entry.ps1_addr == 0 ||
                     (cdb.ready && cdb.pr_dest == dispatch_entry.ps1_addr);
            n.r2   = dispatch_entry.ps2_ready || dispatch_entry.ps2_addr == 0 ||
                     (cdb.ready && cdb.pr_dest == dispatch_entry.ps2_addr);
            mq.push_back(n);
         end
      end
   end

   function automatic rs_entry_t mk(input logic [2:0] f, input int rob, input int p1, input bit r1,
                                    input int p2, input bit r2);
      rs_entry_t e;
      e           = '0;
      e.funct3    = f;
      e.rob_id    = ROB_IDX_W'(rob);
      e.rd_addr   = 5'(rob + 1);
      e.pd_addr   = PR_IDX_W'(32 + rob);
      e.ps1_addr  = PR_IDX_W'(p1);
      e.ps1_ready = r1;
      e.ps2_addr  = PR_IDX_W'(p2);
      e.ps2_ready = r2;
      return e;
   endfunction

   task automatic bcast(input bit v, input int pr);
      cdb         = '0;
      cdb.ready   = v;
      cdb.pr_dest = PR_IDX_W'(pr);
   endtask

   task automatic dispatch(input rs_entry_t e);
      dispatch_valid = 1'b1;
      dispatch_entry = e;
   endtask

   task automatic idle();
      dispatch_valid = 1'b0;
      flush          = 1'b0;
      bcast(1'b0, 0);
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      fu_ready = 1'b1;
      repeat (2) advance();
      rst    = 1'b0;
      mon_en = 1'b1;
      sample();
      vectors++;
      if (dispatch_ready !== 1'b1 || rs_entry_valid !== 1'b0 || occupancy !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got ready %0b valid %0b occ %0d expected 1 0 0",
                  dispatch_ready, rs_entry_valid, occupancy);
      end
      advance();
   endtask

   task automatic test_basic_issue();
      fu_ready = 1'b1;
      dispatch(mk(DIVU, 1, 5, 1'b1, 6, 1'b1));
      sample();
      vectors++;
      if (rs_entry_valid !== 1'b0 || occupancy !== '0) begin
         miscompares++;
         $display("FAIL basic_before: got valid %0b occ %0d expected 0 0", rs_entry_valid, occupancy);
      end
      advance();
      idle();
      sample();
      vectors++;
      if (rs_entry_valid !== 1'b1 || ps1_addr !== 6'd5 || ps2_addr !== 6'd6 ||
          occupancy !== 3'd1 || rs_entry_dout.funct3 !== DIVU) begin
         miscompares++;
         $display("FAIL basic_issue: got valid %0b ps1 %0d ps2 %0d occ %0d f3 %0d expected 1 5 6 1 5",
                  rs_entry_valid, ps1_addr, ps2_addr, occupancy, rs_entry_dout.funct3);
      end
      advance();
      sample();
      vectors++;
      if (rs_entry_valid !== 1'b0 || occupancy !== '0) begin
         miscompares++;
         $display("FAIL basic_drain: got valid %0b occ %0d expected 0 0", rs_entry_valid, occupancy);
      end
      advance();
   endtask

   task automatic test_wakeup_latency();
      fu_ready = 1'b1;
      dispatch(mk(REM, 2, 3, 1'b1, 9, 1'b0));
      for (int c = 0; c < 4; c++) begin
         if (c == 1) idle();
         if (c == 2) bcast(1'b1, 9);
         if (c == 3) bcast(1'b0, 0);
         sample();
         vectors++;
         if (rs_entry_valid !== (c == 3)) begin
            miscompares++;
            $display("FAIL wakeup_cycle%0d: got valid %0b expected %0b", c, rs_entry_valid, c == 3);
         end
         if (c == 3) begin
            vectors++;
            if (ps2_addr !== 6'd9 || rs_entry_dout.rob_id !== 4'd2) begin
               miscompares++;
               $display("FAIL wakeup_entry: got ps2 %0d rob %0d expected 9 2", ps2_addr, rs_entry_dout.rob_id);
            end
         end
         advance();
      end
   endtask

   task automatic test_dispatch_wakeup();
      fu_ready = 1'b1;
      dispatch(mk(MUL, 3, 12, 1'b0, 4, 1'b1));
      bcast(1'b1, 12);
      sample();
      vectors++;
      if (rs_entry_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL same_cycle_wake_early: got valid %0b expected 0", rs_entry_valid);
      end
      advance();
      idle();
      sample();
      vectors++;
      if (rs_entry_valid !== 1'b1 || ps1_addr !== 6'd12) begin
         miscompares++;
         $display("FAIL same_cycle_wake: got valid %0b ps1 %0d expected 1 12", rs_entry_valid, ps1_addr);
      end
      advance();
   endtask

   task automatic test_full();
      int  issued;
      bit  dropped_seen;
      fu_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         dispatch(mk(MULHU, 4 + k, 1 + k, 1'b1, 2 + k, 1'b1));
         sample();
         vectors++;
         if (dispatch_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_ready%0d: got %0b expected 1", k, dispatch_ready);
         end
         advance();
      end
      dispatch(mk(MULH, 9, 7, 1'b1, 7, 1'b1));
      sample();
      vectors++;
      if (dispatch_ready !== 1'b0 || occupancy !== 3'd4) begin
         miscompares++;
         $display("FAIL full: got ready %0b occ %0d expected 0 4", dispatch_ready, occupancy);
      end
      advance();
      idle();
      fu_ready = 1'b1;
      sample();
      vectors++;
      if (occupancy !== 3'd4 || rs_entry_valid !== 1'b1 || dispatch_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_issue: got occ %0d valid %0b ready %0b expected 4 1 0",
                  occupancy, rs_entry_valid, dispatch_ready);
      end
      advance();
      fu_ready = 1'b0;
      sample();
      vectors++;
      if (dispatch_ready !== 1'b1 || occupancy !== 3'd3) begin
         miscompares++;
         $display("FAIL after_issue: got ready %0b occ %0d expected 1 3", dispatch_ready, occupancy);
      end
      advance();
      fu_ready     = 1'b1;
      issued       = 0;
      dropped_seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         sample();
         if (rs_entry_valid === 1'b1) begin
            issued++;
            if (rs_entry_dout.rob_id === 4'd9) dropped_seen = 1'b1;
         end
         advance();
      end
      vectors++;
      if (issued != 3 || dropped_seen || occupancy !== '0) begin
         miscompares++;
         $display("FAIL drain: got issued %0d dropped_seen %0b occ %0d expected 3 0 0",
                  issued, dropped_seen, occupancy);
      end
   endtask

   task automatic test_issue_order();
      int exp_rob[3];
`ifdef MULDIV_RS_OLDEST_FIRST_EN
      exp_rob = '{2, 3, 4};
`else
      exp_rob = '{4, 2, 3};
`endif
      fu_ready = 1'b0;
      dispatch(mk(DIV, 1, 20, 1'b0, 0, 1'b0));
      advance();
      dispatch(mk(REMU, 2, 21, 1'b1, 22, 1'b1));
      advance();
      dispatch(mk(MULHSU, 3, 23, 1'b1, 24, 1'b1));
      advance();
      idle();
      bcast(1'b1, 20);
      advance();
      idle();
      fu_ready = 1'b1;
      sample();
      vectors++;
      if (rs_entry_valid !== 1'b1 || rs_entry_dout.rob_id !== 4'd1) begin
         miscompares++;
         $display("FAIL order_free_a: got valid %0b rob %0d expected 1 1", rs_entry_valid, rs_entry_dout.rob_id);
      end
      advance();
      fu_ready = 1'b0;
      dispatch(mk(MUL, 4, 25, 1'b1, 26, 1'b1));
      advance();
      idle();
      fu_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sample();
         vectors++;
         if (rs_entry_valid !== 1'b1 || rs_entry_dout.rob_id !== ROB_IDX_W'(exp_rob[k])) begin
            miscompares++;
            $display("FAIL order%0d: got valid %0b rob %0d expected 1 %0d", k, rs_entry_valid,
                     rs_entry_dout.rob_id, exp_rob[k]);
         end
         advance();
      end
   endtask

   task automatic test_flush();
      fu_ready = 1'b0;
      dispatch(mk(MUL, 1, 1, 1'b1, 2, 1'b1));
      advance();
      dispatch(mk(DIV, 2, 3, 1'b1, 4, 1'b1));
      advance();
      dispatch(mk(REM, 3, 15, 1'b0, 4, 1'b1));
      advance();
      dispatch(mk(REMU, 7, 5, 1'b1, 6, 1'b1));
      flush    = 1'b1;
      fu_ready = 1'b1;
      bcast(1'b1, 15);
      sample();
      vectors++;
      if (rs_entry_valid !== 1'b0 || occupancy !== 3'd3) begin
         miscompares++;
         $display("FAIL flush_cycle: got valid %0b occ %0d expected 0 3", rs_entry_valid, occupancy);
      end
      advance();
      idle();
      for (int c = 0; c < 3; c++) begin
         sample();
         vectors++;
         if (rs_entry_valid !== 1'b0 || occupancy !== '0 || dispatch_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_flush%0d: got valid %0b occ %0d ready %0b expected 0 0 1",
                     c, rs_entry_valid, occupancy, dispatch_ready);
         end
         advance();
      end
      dispatch(mk(MULH, 8, 13, 1'b0, 14, 1'b0));
      advance();
      idle();
      for (int c = 0; c < 3; c++) begin
         bcast(1'b1, 0);
         sample();
         vectors++;
         if (rs_entry_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_dest_wake%0d: got valid %0b expected 0", c, rs_entry_valid);
         end
         advance();
      end
      bcast(1'b1, 13);
      advance();
      bcast(1'b1, 14);
      advance();
      idle();
      sample();
      vectors++;
      if (rs_entry_valid !== 1'b1 || rs_entry_dout.rob_id !== 4'd8) begin
         miscompares++;
         $display("FAIL late_wake: got valid %0b rob %0d expected 1 8", rs_entry_valid, rs_entry_dout.rob_id);
      end
      advance();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         dispatch_valid = ($urandom_range(0, 9) < 6);
         dispatch_entry = mk(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         bcast(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
         cdb.rd_data = $urandom();
         fu_ready    = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 49) == 0);
         advance();
      end
      idle();
      fu_ready = 1'b0;
      advance();
   endtask

   initial begin
      test_reset();
      test_basic_issue();
      test_wakeup_latency();
      test_dispatch_wakeup();
      test_full();
      test_issue_order();
      test_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
